// File: rtl/clk_div_pkg.sv
// Shared constants and channel-mode helper for the multi-channel clock divider.
// CLK_DIV_DUTY_EN selects duty mode (CLK_out high while cnt < H) instead of toggle mode.
package clk_div_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int MAX_NCH   = 16;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_DUTY   = 1'b1
    } ch_mode_e;

`ifdef CLK_DIV_DUTY_EN
    localparam ch_mode_e CH_MODE = MODE_DUTY;
`else
    localparam ch_mode_e CH_MODE = MODE_TOGGLE;
`endif

    // Output level right after a wrap: toggle flips, duty starts high unless H == 0.
    function automatic logic wrap_level(ch_mode_e mode, logic cur, logic hi_set);
        return (mode == MODE_DUTY) ? hi_set : ~cur;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control/status bundle between the divider and its user.
interface clk_div_multi_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 32
);
    logic                 en;
    logic [NCH-1:0]       load;
    logic [NCH*WIDTH-1:0] div_in;
    logic [NCH*WIDTH-1:0] hi_in;
    logic [NCH-1:0]       CLK_out;
    logic [NCH-1:0]       tick_out;
    logic [NCH-1:0]       busy;

    modport master (
        output en, load, div_in, hi_in,
        input  CLK_out, tick_out, busy
    );

    modport slave (
        input  en, load, div_in, hi_in,
        output CLK_out, tick_out, busy
    );
endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/pending divisor, registered clock and tick.
// CLK_DIV_DUTY_EN adds per-channel high time H captured alongside the divisor.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(19999999)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div,
`ifdef CLK_DIV_DUTY_EN
    input  logic [WIDTH-1:0] hi,
`endif
    output logic             clk_div,
    output logic             tick,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt, d, p;
    logic [WIDTH-1:0] cnt_nx, d_nx, p_nx;
    logic             busy_nx, tick_nx, clk_nx, wrap, hi_set;

`ifdef CLK_DIV_DUTY_EN
    logic [WIDTH-1:0] h, ph, h_nx, ph_nx;
    assign hi_set = (h_nx != '0);
`else
    assign hi_set = 1'b0;
`endif

    assign wrap = (d != '0) && (cnt == d - ONE);

    always_comb begin
        cnt_nx  = cnt;
        d_nx    = d;
        p_nx    = p;
        busy_nx = busy;
        tick_nx = 1'b0;
        clk_nx  = clk_div;
`ifdef CLK_DIV_DUTY_EN
        h_nx    = h;
        ph_nx   = ph;
`endif
        if (d == '0) begin
            // Stopped channel takes a new divisor immediately, independent of en.
            if (load) begin
                d_nx   = div;
                cnt_nx = '0;
                clk_nx = 1'b0;
`ifdef CLK_DIV_DUTY_EN
                h_nx   = hi;
`endif
            end
        end else if (en) begin
            if (wrap) begin
                cnt_nx  = '0;
                tick_nx = 1'b1;
                if (load) begin
                    d_nx    = div;
                    busy_nx = 1'b0;
`ifdef CLK_DIV_DUTY_EN
                    h_nx    = hi;
`endif
                end else if (busy) begin
                    d_nx    = p;
                    busy_nx = 1'b0;
`ifdef CLK_DIV_DUTY_EN
                    h_nx    = ph;
`endif
                end
                clk_nx = wrap_level(CH_MODE, clk_div, hi_set);
                if (d_nx == '0) begin
                    clk_nx  = 1'b0;
                    tick_nx = 1'b0;
                end
            end else begin
                cnt_nx = cnt + ONE;
                if (load) begin
                    p_nx    = div;
                    busy_nx = 1'b1;
`ifdef CLK_DIV_DUTY_EN
                    ph_nx   = hi;
`endif
                end
`ifdef CLK_DIV_DUTY_EN
                clk_nx = (cnt_nx < h);
`endif
            end
        end else if (load) begin
            p_nx    = div;
            busy_nx = 1'b1;
`ifdef CLK_DIV_DUTY_EN
            ph_nx   = hi;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            d       <= DEFAULT_DIV;
            p       <= '0;
            busy    <= 1'b0;
            tick    <= 1'b0;
            clk_div <= 1'b0;
`ifdef CLK_DIV_DUTY_EN
            h       <= DEFAULT_DIV >> 1;
            ph      <= '0;
`endif
        end else begin
            cnt     <= cnt_nx;
            d       <= d_nx;
            p       <= p_nx;
            busy    <= busy_nx;
            tick    <= tick_nx;
            clk_div <= clk_nx;
`ifdef CLK_DIV_DUTY_EN
            h       <= h_nx;
            ph      <= ph_nx;
`endif
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// NCH independent programmable clock dividers sharing one clock, reset and enable.
// CLK_DIV_DUTY_EN switches all channels to duty mode using hi_in.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int               NCH         = 4,
    parameter int               WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(19999999)
) (
    input  logic           CLK_in,
    input  logic           RST,
    clk_div_multi_if.slave bus
);

`ifndef CLK_DIV_DUTY_EN
    logic unused_hi;
    assign unused_hi = ^bus.hi_in;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clk_div_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (CLK_in),
            .rst     (RST),
            .en      (bus.en),
            .load    (bus.load[i]),
            .div     (bus.div_in[i*WIDTH +: WIDTH]),
`ifdef CLK_DIV_DUTY_EN
            .hi      (bus.hi_in[i*WIDTH +: WIDTH]),
`endif
            .clk_div (bus.CLK_out[i]),
            .tick    (bus.tick_out[i]),
            .busy    (bus.busy[i])
        );
    end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel programmable clock divider: generalises the fixed-ratio single-output divider into NCH independent channels, each with a runtime-loadable divisor, a divided clock output, and a one-cycle tick strobe. Divisor changes are glitch-free because they take effect only at the channel's next wrap. It sits beside the board clock and feeds button debouncers, display scanning, and counters that need several slow rates from one clock.

## Interface
- NCH, 4: number of independent channels (1..16)
- WIDTH, 32: divisor/counter width per channel
- DEFAULT_DIV, 19999999: divisor loaded into every channel at reset; must be < 2^WIDTH

- CLK_in  input  1  system clock; all logic on rising edge
- RST  input  1  reset; synchronous and active-high
- en  input  1  global count enable; low freezes all counters and outputs
- load  input  NCH  per-channel load strobe, one cycle
- div_in  input  NCH*WIDTH  new divisor; channel i at bits [i*WIDTH +: WIDTH]
- hi_in  input  NCH*WIDTH  high time for duty mode; ignored unless CLK_DIV_DUTY_EN
- CLK_out  output  NCH  divided clock per channel
- tick_out  output  NCH  one-cycle pulse at each channel wrap
- busy  output  NCH  load accepted but not yet applied

## Operation
- Per channel: active divisor D, counter cnt (0..D-1), pending divisor P with valid flag (busy).
- D ≥ 1: cnt increments on each en-high edge; at cnt == D-1, cnt <= 0 (wrap), tick_out <= 1, CLK_out toggles. All other edges: tick_out <= 0.
- Toggle-mode period of CLK_out = 2·D cycles; D = N matches the legacy fixed divider.
- D = 0: channel stopped; cnt held 0, CLK_out and tick_out held 0.
- load[i] high: P <= div_in slice, busy[i] <= 1. Applied (D <= P, busy <= 0) at next wrap.
- Load in same cycle as wrap: new value applied directly at that wrap; busy never rises.
- Load to a stopped channel (D = 0): applied on next edge regardless of en, cnt <= 0, CLK_out <= 0.
- Load while busy: P overwritten; only latest value applied.
- Loading 0: channel stops at next wrap with CLK_out and tick_out forced 0.
- en low: cnt, CLK_out, tick_out frozen (tick_out forced 0); loads still captured; pending waits for a wrap.
- Arithmetic: cnt is WIDTH bits, compare only, no overflow possible since cnt < D ≤ 2^WIDTH-1.

## Timing
- Reset (RST high at an edge): cnt = 0, D = DEFAULT_DIV, P = 0, busy = 0, CLK_out = 0, tick_out = 0 for all channels. Reset mid-operation drops any pending load.
- After reset release, first tick_out high in cycle D (edge D after the last reset edge), high for exactly one cycle; CLK_out rises on the same edge.
- load to busy: 1 cycle latency. Channels fully independent; simultaneous loads on several channels all accepted.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- CLK_DIV_DUTY_EN defined: per-channel high time H captured with D (from hi_in at load, DEFAULT_DIV/2 at reset). CLK_out = 1 while cnt < H, else 0, giving period D and duty H/D; H ≥ D gives constant 1, H = 0 constant 0. tick_out unchanged.
- Undefined: toggle mode only; hi_in unused, no H registers synthesised.

## Structure
- Package clk_div_pkg: default WIDTH, max NCH constant, and the channel mode constants (toggle/duty).
- One sub-module clk_div_channel (single channel: counter, D/P/busy, outputs), instantiated NCH times via generate; top only slices buses and fans out CLK_in, RST, en.

## Test plan
- Reset with DEFAULT_DIV overridden to 5, NCH = 2 -> tick_out pulses in cycles 5, 10, 15; CLK_out toggles at same edges (period 10).
- Channel 0 D = 4, pulse load with div_in = 2 at cnt = 1 -> busy high cycles until wrap at cnt = 3, then ticks every 2 cycles; channel 1 unaffected.
- Load div_in = 3 exactly in wrap cycle -> busy stays 0, next tick 3 cycles later; load 7 then 9 while busy -> only 9 applied.
- Load 0 -> channel stops at next wrap, outputs 0; later load 2 -> counting resumes next edge, first tick 2 cycles later.
- en low for 10 cycles mid-period -> cnt, CLK_out frozen, tick_out 0; resumes at same count; RST mid-busy -> busy 0, D = DEFAULT_DIV.
- With CLK_DIV_DUTY_EN, load D = 5, H = 2 -> CLK_out high 2 cycles, low 3, repeating; H = 0 -> constant 0.
